// File: rtl/requant_stream_4n.sv
// Captures sixteen signed ReLU activations, requantizes them to unsigned bytes,
// and streams them out one per cycle on a valid/ready byte interface.
module requant_stream_4n #(
  parameter int QIN_SIZE = 17,
  parameter int QSHIFT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [QIN_SIZE-1:0] in0_n0,
  input  logic signed [QIN_SIZE-1:0] in1_n0,
  input  logic signed [QIN_SIZE-1:0] in2_n0,
  input  logic signed [QIN_SIZE-1:0] in3_n0,
  input  logic signed [QIN_SIZE-1:0] in0_n1,
  input  logic signed [QIN_SIZE-1:0] in1_n1,
  input  logic signed [QIN_SIZE-1:0] in2_n1,
  input  logic signed [QIN_SIZE-1:0] in3_n1,
  input  logic signed [QIN_SIZE-1:0] in0_n2,
  input  logic signed [QIN_SIZE-1:0] in1_n2,
  input  logic signed [QIN_SIZE-1:0] in2_n2,
  input  logic signed [QIN_SIZE-1:0] in3_n2,
  input  logic signed [QIN_SIZE-1:0] in0_n3,
  input  logic signed [QIN_SIZE-1:0] in1_n3,
  input  logic signed [QIN_SIZE-1:0] in2_n3,
  input  logic signed [QIN_SIZE-1:0] in3_n3,
  input  logic                       relu_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic [3:0]                 out_idx,
  output logic                       out_last,
  output logic                       overflow
);

  // Output handshake: a byte moves on any cycle where out_valid && out_ready;
  // while out_valid is high and out_ready is low, data/idx/last hold steady.

  typedef enum logic {IDLE, STREAM} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       overflow_q, overflow_d;
  logic       capture;
  logic [7:0] frame_q [16];
  logic [7:0] rq [16];

  // Shift, then clamp: negative -> 0, anything above the low byte -> 255.
  function automatic logic [7:0] requant(input logic signed [QIN_SIZE-1:0] x);
    logic signed [QIN_SIZE-1:0] q;
    q = x >>> QSHIFT;
    if (q[QIN_SIZE-1])
      return 8'd0;
    else if (|q[QIN_SIZE-2:8])
      return 8'hFF;
    else
      return q[7:0];
  endfunction

  always_comb begin
    rq[0]  = requant(in0_n0);
    rq[1]  = requant(in1_n0);
    rq[2]  = requant(in2_n0);
    rq[3]  = requant(in3_n0);
    rq[4]  = requant(in0_n1);
    rq[5]  = requant(in1_n1);
    rq[6]  = requant(in2_n1);
    rq[7]  = requant(in3_n1);
    rq[8]  = requant(in0_n2);
    rq[9]  = requant(in1_n2);
    rq[10] = requant(in2_n2);
    rq[11] = requant(in3_n2);
    rq[12] = requant(in0_n3);
    rq[13] = requant(in1_n3);
    rq[14] = requant(in2_n3);
    rq[15] = requant(in3_n3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < 16; k++) frame_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      if (capture) begin
        for (int k = 0; k < 16; k++) frame_q[k] <= rq[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (relu_ready) begin
          capture = 1'b1;
          idx_d   = 4'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
          end else begin
            idx_d = 4'd0;
            // A frame arriving with the last byte's transfer chains without a bubble.
            if (relu_ready) capture = 1'b1;
            else            state_d = IDLE;
          end
        end
        if (relu_ready && !capture) overflow_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == STREAM);
    out_data  = out_valid ? frame_q[idx_q] : 8'd0;
    out_idx   = out_valid ? idx_q : 4'd0;
    out_last  = out_valid && (idx_q == 4'd15);
    overflow  = overflow_q;
  end

endmodule
